// File: rtl/mfft_output_reorder_pkg.sv
// Shared definitions for the FFT output reorder block: state encoding and NFFT derivation.
package mfft_output_reorder_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } reorder_state_t;

    function automatic int calc_nfft(input int size_buffer);
        return 1 << size_buffer;
    endfunction

endpackage

// File: rtl/mfft_output_reorder_if.sv
// Butterfly-pair input bus and natural-order output bus of the FFT output reorder block.
interface mfft_output_reorder_if #(
    parameter int SIZE_BUFFER   = 3,
    parameter int SIZE_OUT_DATA = 16
);
    logic [SIZE_OUT_DATA-1:0] in_lo_i;
    logic [SIZE_OUT_DATA-1:0] in_lo_q;
    logic [SIZE_OUT_DATA-1:0] in_hi_i;
    logic [SIZE_OUT_DATA-1:0] in_hi_q;
    logic                     in_valid;
    logic                     in_ready;
    logic                     frame_done;
    logic [SIZE_OUT_DATA-1:0] out_i;
    logic [SIZE_OUT_DATA-1:0] out_q;
    logic                     out_valid;
    logic [SIZE_BUFFER-1:0]   out_index;
    logic                     out_last;
    logic                     overflow;

    modport master (
        output in_lo_i, in_lo_q, in_hi_i, in_hi_q, in_valid,
        input  in_ready, frame_done, out_i, out_q, out_valid, out_index, out_last, overflow
    );

    modport slave (
        input  in_lo_i, in_lo_q, in_hi_i, in_hi_q, in_valid,
        output in_ready, frame_done, out_i, out_q, out_valid, out_index, out_last, overflow
    );
endinterface

// File: rtl/mfft_reorder_ram.sv
// Single-clock simple dual-port RAM with registered read; holds the upper-half bins of a frame.
module mfft_reorder_ram #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto block RAM; every word is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/mfft_output_reorder.sv
// Reorders butterfly lo/hi pairs into natural bin order: lo bins pass straight through,
// hi bins are buffered and drained contiguously right behind them.
module mfft_output_reorder
    import mfft_output_reorder_pkg::*;
#(
    parameter int SIZE_BUFFER   = 3,
    parameter int SIZE_OUT_DATA = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mfft_output_reorder_if.slave bus
);
    localparam int NFFT   = calc_nfft(SIZE_BUFFER);
    localparam int HALF   = NFFT / 2;
    localparam int CNT_W  = SIZE_BUFFER - 1;
    localparam int DATA_W = 2 * SIZE_OUT_DATA;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF - 1);

    reorder_state_t           state;
    logic [CNT_W-1:0]         wr_cnt;
    logic [CNT_W-1:0]         rd_cnt;
    logic                     drain_tail;
    logic                     src_ram;
    logic [SIZE_OUT_DATA-1:0] lo_i_reg;
    logic [SIZE_OUT_DATA-1:0] lo_q_reg;
    logic [DATA_W-1:0]        ram_rdata;
    logic                     accept;
    logic                     rd_en;

    assign accept         = bus.in_valid && (state == COLLECT) && !reset;
    assign rd_en          = (state == DRAIN) && !drain_tail && !reset;
    assign bus.frame_done = accept && (wr_cnt == LAST_CNT);

    // Registered RAM data and the lo register share the output, so drain adds no extra cycle.
    assign bus.out_i = src_ram ? ram_rdata[DATA_W-1 -: SIZE_OUT_DATA] : lo_i_reg;
    assign bus.out_q = src_ram ? ram_rdata[SIZE_OUT_DATA-1:0]         : lo_q_reg;

    mfft_reorder_ram #(
        .DEPTH  (HALF),
        .ADDR_W (CNT_W),
        .DATA_W (DATA_W)
    ) u_hi_mem (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_cnt),
        .wr_data ({bus.in_hi_i, bus.in_hi_q}),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt),
        .rd_data (ram_rdata)
    );

    // NOTE: all state here updates with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= COLLECT;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            drain_tail    <= 1'b0;
            src_ram       <= 1'b0;
            lo_i_reg      <= '0;
            lo_q_reg      <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_index <= '0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            src_ram       <= 1'b0;
            if (bus.in_valid && !bus.in_ready) bus.overflow <= 1'b1;

            case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        lo_i_reg      <= bus.in_lo_i;
                        lo_q_reg      <= bus.in_lo_q;
                        bus.out_valid <= 1'b1;
                        bus.out_index <= {1'b0, wr_cnt};
                        if (wr_cnt == LAST_CNT) begin
                            wr_cnt       <= '0;
                            rd_cnt       <= '0;
                            state        <= DRAIN;
                            bus.in_ready <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Tail cycle lets the last hi bin leave before accepting the next frame.
                    if (!drain_tail) begin
                        src_ram       <= 1'b1;
                        bus.out_valid <= 1'b1;
                        bus.out_index <= {1'b1, rd_cnt};
                        bus.out_last  <= (rd_cnt == LAST_CNT);
                        if (rd_cnt == LAST_CNT) begin
                            rd_cnt     <= '0;
                            drain_tail <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end else begin
                        drain_tail   <= 1'b0;
                        state        <= COLLECT;
                        bus.in_ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mfft_output_reorder.sv
// Scoreboard bench for mfft_output_reorder with NFFT=8: expected bins and their due cycles are
// queued as pairs are driven and compared as the DUT emits them.
module tb_mfft_output_reorder;
    localparam int SB = 3;
    localparam int DW = 16;

    typedef struct {
        int            idx;
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic          last;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   mdl_cnt = 0;
    int   ready_cyc = 0;
    logic [DW-1:0] mdl_hi_i [4];
    logic [DW-1:0] mdl_hi_q [4];
    exp_t sb [$];

    mfft_output_reorder_if #(.SIZE_BUFFER(SB), .SIZE_OUT_DATA(DW)) bus ();

    mfft_output_reorder #(.SIZE_BUFFER(SB), .SIZE_OUT_DATA(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_cycle", cyc, e.due);
                    check("out_index", 32'(bus.out_index), e.idx);
                    check("out_i", 32'(bus.out_i), 32'(e.i));
                    check("out_q", 32'(bus.out_q), 32'(e.q));
                    check("out_last", 32'(bus.out_last), 32'(e.last));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("missing_valid", 32'(bus.out_valid), 32'd1);
            end
        end
    end

    task automatic send(input logic [DW-1:0] li, input logic [DW-1:0] lq,
                        input logic [DW-1:0] hi, input logic [DW-1:0] hq, input int gap);
        int acc;
        while (cyc < ready_cyc) step();
        check("in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_lo_i  = li;
        bus.in_lo_q  = lq;
        bus.in_hi_i  = hi;
        bus.in_hi_q  = hq;
        bus.in_valid = 1'b1;
        #1;
        check("frame_done", 32'(bus.frame_done), (mdl_cnt == 3) ? 32'd1 : 32'd0);
        step();
        acc = cyc;
        bus.in_valid = 1'b0;
        mdl_hi_i[mdl_cnt] = hi;
        mdl_hi_q[mdl_cnt] = hq;
        sb.push_back('{idx: mdl_cnt, i: li, q: lq, last: 1'b0, due: acc});
        if (mdl_cnt == 3) begin
            for (int k = 0; k < 4; k++)
                sb.push_back('{idx: 4 + k, i: mdl_hi_i[k], q: mdl_hi_q[k], last: (k == 3), due: acc + 1 + k});
            ready_cyc = acc + 5;
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
        repeat (gap) step();
    endtask

    task automatic do_reset(input logic with_valid);
        @(negedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = with_valid;
        bus.in_lo_i  = 16'hDEAD;
        bus.in_lo_q  = 16'hBEEF;
        bus.in_hi_i  = 16'hCAFE;
        bus.in_hi_q  = 16'hF00D;
        #1;
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_index", 32'(bus.out_index), 32'd0);
        check("rst_out_i", 32'(bus.out_i), 32'd0);
        check("rst_out_q", 32'(bus.out_q), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        mdl_cnt      = 0;
        ready_cyc    = cyc;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_lo_i  = '0;
        bus.in_lo_q  = '0;
        bus.in_hi_i  = '0;
        bus.in_hi_q  = '0;
        repeat (2) step();
        do_reset(1'b0);

        // Consecutive pairs lo=k, hi=10+k
        for (int k = 0; k < 4; k++)
            send(DW'(k), DW'(16'h100 + k), DW'(10 + k), DW'(16'h200 + k), 0);

        // One-cycle gaps between pairs
        for (int k = 0; k < 4; k++)
            send(DW'(16'h20 + k), DW'(16'h120 + k), DW'(16'h30 + k), DW'(16'h230 + k), 1);

        // Two frames back to back, second starting as soon as in_ready returns
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 4; k++)
                send(DW'(16'h1000 * (f + 1) + k), DW'(16'h1100 * (f + 1) + k),
                     DW'(16'h1200 * (f + 1) + k), DW'(16'h1300 * (f + 1) + k), 0);
        check("overflow_b2b", 32'(bus.overflow), 32'd0);

        // Extreme codes pass bit-exact
        for (int k = 0; k < 4; k++)
            send(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 0);

        // Stray in_valid on the second drain cycle
        for (int k = 0; k < 4; k++)
            send(DW'(16'h40 + k), DW'(16'h140 + k), DW'(16'h50 + k), DW'(16'h250 + k), 0);
        step();
        bus.in_lo_i  = 16'hBAD0;
        bus.in_lo_q  = 16'hBAD1;
        bus.in_hi_i  = 16'hBAD2;
        bus.in_hi_q  = 16'hBAD3;
        bus.in_valid = 1'b1;
        #1;
        check("drain_in_ready", 32'(bus.in_ready), 32'd0);
        check("drain_frame_done", 32'(bus.frame_done), 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("overflow_set", 32'(bus.overflow), 32'd1);
        for (int k = 0; k < 4; k++)
            send(DW'(16'h60 + k), DW'(16'h160 + k), DW'(16'h70 + k), DW'(16'h270 + k), 0);
        check("overflow_held", 32'(bus.overflow), 32'd1);

        // Reset mid-collect abandons the partial frame
        send(16'h0A0, 16'h0A1, 16'h0A2, 16'h0A3, 0);
        send(16'h0B0, 16'h0B1, 16'h0B2, 16'h0B3, 0);
        do_reset(1'b1);
        for (int k = 0; k < 4; k++)
            send(DW'(16'h80 + k), DW'(16'h180 + k), DW'(16'h90 + k), DW'(16'h290 + k), 0);
        check("overflow_after_rst", 32'(bus.overflow), 32'd0);

        repeat (10) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/mfft_output_reorder.md
MFFT_OUTPUT_REORDER -- requirements
Module: mfft_output_reorder

Interface
REQ-001 SHALL have parameter SIZE_BUFFER, default 3; log2(NFFT), NFFT = 1 << SIZE_BUFFER.
REQ-002 SHALL have parameter SIZE_OUT_DATA, default 16; width of each I/Q sample.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_lo_i, in_lo_q  input  SIZE_OUT_DATA each  butterfly result for bins 0..NFFT/2-1.
REQ-006 SHALL have port in_hi_i, in_hi_q  input  SIZE_OUT_DATA each  butterfly result for bins NFFT/2..NFFT-1.
REQ-007 SHALL have port in_valid  input  1  the lo/hi pair is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  high while the block accepts pairs (COLLECT state).
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when the NFFT/2-th pair is accepted; drives the upstream mutDone.
REQ-010 SHALL have port out_i, out_q  output  SIZE_OUT_DATA each  output sample in natural bin order.
REQ-011 SHALL have port out_valid  output  1  out_i/out_q/out_index are valid.
REQ-012 SHALL have port out_index  output  SIZE_BUFFER  bin number of the current output sample.
REQ-013 SHALL have port out_last  output  1  high with out_valid on bin NFFT-1.
REQ-014 SHALL have port overflow  output  1  sticky; set when in_valid arrives while in_ready is low.

Function
REQ-015 SHALL implement two states: COLLECT and DRAIN.
REQ-016 COLLECT: on in_valid, SHALL write the hi pair to hi_mem[wr_cnt] and register the lo pair to out_i/out_q, with out_valid=1 and out_index=wr_cnt on the next cycle (1-cycle latency).
REQ-017 COLLECT: wr_cnt (SIZE_BUFFER-1 bits) SHALL increment only on an accepted pair; gaps in in_valid SHALL hold wr_cnt (no restart).
REQ-018 An accepted pair with wr_cnt == NFFT/2-1 SHALL pulse frame_done in the same cycle as the acceptance, clear wr_cnt, and move to DRAIN on the next edge.
REQ-019 DRAIN: in_ready SHALL be 0; the block SHALL read hi_mem[rd_cnt] every cycle, rd_cnt 0..NFFT/2-1, with 1-cycle synchronous read latency.
REQ-020 DRAIN output SHALL be contiguous: out_valid=1, out_index=NFFT/2+rd_cnt, and bin NFFT/2 SHALL appear exactly one cycle after bin NFFT/2-1.
REQ-021 out_last SHALL assert with bin NFFT-1 only; on the following cycle the state SHALL return to COLLECT and out_valid SHALL drop to 0 unless a new pair was accepted.
REQ-022 in_valid while in_ready=0 SHALL be ignored (no write, no output) and SHALL set overflow; only reset clears overflow.
REQ-023 out_valid SHALL be 0 in every cycle not covered by REQ-016 or REQ-020.
REQ-024 Samples SHALL pass bit-exact; no rounding, saturation, or sign extension.
REQ-025 Back-to-back frames SHALL be supported: the first pair of the next frame may arrive on the cycle in_ready returns to 1.

Reset
REQ-026 Reset SHALL force: state=COLLECT, wr_cnt=0, rd_cnt=0, in_ready=1, out_valid=0, out_last=0, frame_done=0, overflow=0, out_index=0, out_i=out_q=0.
REQ-027 Reset asserted mid-COLLECT or mid-DRAIN SHALL abandon the partial frame; hi_mem contents need not be cleared.
REQ-028 in_valid during the reset cycle SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the state encoding (COLLECT/DRAIN) and the NFFT derivation from SIZE_BUFFER.
REQ-030 hi_mem SHALL be one sub-module, mfft_reorder_ram: single-clock simple dual-port RAM, depth NFFT/2, width 2*SIZE_OUT_DATA, registered read.

Verification
REQ-031 NFFT=8; 4 consecutive pairs lo=k, hi=10+k -> out bins 0..7 = 0,1,2,3,10,11,12,13; out_valid high 8 consecutive cycles; out_last on index 7; frame_done pulse on the 4th acceptance.
REQ-032 NFFT=8; pairs with 1-cycle gaps -> lo outputs follow the gaps, indices 0..3 with no restart; drain stays contiguous 4..7.
REQ-033 in_valid asserted on the 2nd DRAIN cycle -> no change in output order, overflow=1 and held until reset.
REQ-034 reset for one cycle after 2 pairs, then 4 new pairs -> output indices restart at 0; no stale bins 4..7 from the aborted frame.
REQ-035 Two frames back-to-back, second frame starting on the first in_ready=1 cycle -> 16 valid outputs, indices 0..7 twice, overflow=0.
REQ-036 SIZE_OUT_DATA=16; lo=16'h8000, hi=16'h7FFF -> outputs bit-exact, no saturation.
